// File: rtl/mtr_drv_pkg.sv
// Shared defaults and helpers for the multi-channel H-bridge PWM driver.
package mtr_drv_pkg;

   localparam int MTR_NUM_CH = 2;
   localparam int MTR_SPD_W  = 11;
   localparam int MTR_DEAD_T = 8;

   typedef logic [MTR_SPD_W-1:0] duty_t;

   // Signed speed to offset-binary duty: add half scale, keep spd_w bits.
   function automatic logic [31:0] spd2duty(input logic [31:0] spd, input int unsigned spd_w);
      logic [31:0] half;
      logic [31:0] mask;
      half = 32'd1 << (spd_w - 32'd1);
      mask = (32'd1 << spd_w) - 32'd1;
      return (spd + half) & mask;
   endfunction

endpackage

// File: rtl/mtr_drv_multi_ch.sv
// One motor channel: period-aligned duty shadow, compare, dead-time timer and
// registered complementary outputs.
module pwm_dead_ch
   import mtr_drv_pkg::*;
#(
   parameter int SPD_W  = MTR_SPD_W,
   parameter int DEAD_T = MTR_DEAD_T
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wrap,
   input  logic [SPD_W-1:0] cnt,
   input  logic [SPD_W-1:0] spd,
   output logic             pwm1,
   output logic             pwm2
);

   localparam logic [SPD_W-1:0] DUTY_HALF = {1'b1, {(SPD_W-1){1'b0}}};
   localparam logic [SPD_W-1:0] DT_LOAD   = SPD_W'(DEAD_T);
   localparam logic [SPD_W-1:0] DT_ONE    = SPD_W'(1);

   logic [SPD_W-1:0] duty_sh_q, duty_sh_d;
   logic [SPD_W-1:0] dt_q, dt_d;
   logic             raw_q, raw_d;
   logic             pwm1_q, pwm1_d;
   logic             pwm2_q, pwm2_d;
   logic             dt_tc;

   always_comb begin
      duty_sh_d = duty_sh_q;
      dt_d      = dt_q;
      pwm1_d    = 1'b0;
      pwm2_d    = 1'b0;
      dt_tc     = (dt_q == '0);

      if (wrap) begin
         duty_sh_d = SPD_W'(spd2duty(32'(spd), SPD_W));
      end

      raw_d = (cnt < duty_sh_q);

      // Disabled: park the timer at full dead-time so re-enable starts with
      // a complete off interval; any raw edge restarts the off interval.
      if (!en) begin
         dt_d = DT_LOAD;
      end else if (raw_d != raw_q) begin
         dt_d = DT_LOAD;
      end else if (!dt_tc) begin
         dt_d = dt_q - DT_ONE;
      end

      if (en && dt_tc) begin
         pwm1_d = raw_q;
         pwm2_d = ~raw_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_sh_q <= DUTY_HALF;
         dt_q      <= '0;
         raw_q     <= 1'b0;
         pwm1_q    <= 1'b0;
         pwm2_q    <= 1'b0;
      end else begin
         duty_sh_q <= duty_sh_d;
         dt_q      <= dt_d;
         raw_q     <= raw_d;
         pwm1_q    <= pwm1_d;
         pwm2_q    <= pwm2_d;
      end
   end

   assign pwm1 = pwm1_q;
   assign pwm2 = pwm2_q;

endmodule

// File: rtl/mtr_drv_multi.sv
// Multi-channel H-bridge PWM driver: shared period counter plus one
// dead-time channel slice per motor.
module mtr_drv_multi
   import mtr_drv_pkg::*;
#(
   parameter int NUM_CH = MTR_NUM_CH,
   parameter int SPD_W  = MTR_SPD_W,
   parameter int DEAD_T = MTR_DEAD_T
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [NUM_CH*SPD_W-1:0] spd,
   output logic [NUM_CH-1:0]       pwm1,
   output logic [NUM_CH-1:0]       pwm2,
   output logic                    prd_strt
);

   logic [SPD_W-1:0] cnt_q, cnt_d;
   logic             prd_strt_q, prd_strt_d;
   logic             wrap;

   always_comb begin
      wrap       = (cnt_q == '1);
      cnt_d      = cnt_q + SPD_W'(1);
      // Registered off the wrap so the pulse lines up with cnt == 0.
      prd_strt_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         prd_strt_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         prd_strt_q <= prd_strt_d;
      end
   end

   assign prd_strt = prd_strt_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      pwm_dead_ch #(
         .SPD_W  (SPD_W),
         .DEAD_T (DEAD_T)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .wrap (wrap),
         .cnt  (cnt_q),
         .spd  (spd[k*SPD_W +: SPD_W]),
         .pwm1 (pwm1[k]),
         .pwm2 (pwm2[k])
      );
   end

endmodule

// File: tb/tb_mtr_drv_multi.sv
// Directed bench for mtr_drv_multi: default 2-channel/dead-time-8 instance and
// a 4-channel/no-dead-time instance running side by side.
module tb_mtr_drv_multi;

   logic        clk;
   logic        rst;
   logic        en;
   logic [21:0] spd;
   logic [1:0]  pwm1;
   logic [1:0]  pwm2;
   logic        prd_strt;

   logic [43:0] spd4;
   logic [3:0]  q_pwm1;
   logic [3:0]  q_pwm2;
   logic        q_prd;

   logic [10:0] m_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   int p1 [2];
   int p2 [2];
   int bl [2];
   int q1 [4];
   int q2 [4];
   int qbl, ovl, prd0, prdx, nz;

   mtr_drv_multi u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .spd      (spd),
      .pwm1     (pwm1),
      .pwm2     (pwm2),
      .prd_strt (prd_strt)
   );

   mtr_drv_multi #(.NUM_CH(4), .SPD_W(11), .DEAD_T(0)) u_dut4 (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .spd      (spd4),
      .pwm1     (q_pwm1),
      .pwm2     (q_pwm2),
      .prd_strt (q_prd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference period counter, used only to time stimulus and classify samples.
   always @(posedge clk) begin
      if (rst) m_cnt <= '0;
      else     m_cnt <= m_cnt + 11'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cnt(input logic [10:0] target);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 4200 && !hit; i++) begin
         @(negedge clk);
         if (m_cnt == target) hit = 1'b1;
      end
      if (!hit) chk("wait_cnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic measure(input int n);
      for (int k = 0; k < 2; k++) begin p1[k] = 0; p2[k] = 0; bl[k] = 0; end
      for (int k = 0; k < 4; k++) begin q1[k] = 0; q2[k] = 0; end
      qbl = 0; ovl = 0; prd0 = 0; prdx = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (pwm1[k]) p1[k]++;
            if (pwm2[k]) p2[k]++;
            if (!pwm1[k] && !pwm2[k]) bl[k]++;
            if (pwm1[k] && pwm2[k]) ovl++;
         end
         for (int k = 0; k < 4; k++) begin
            if (q_pwm1[k]) q1[k]++;
            if (q_pwm2[k]) q2[k]++;
            if (!q_pwm1[k] && !q_pwm2[k]) qbl++;
            if (q_pwm1[k] && q_pwm2[k]) ovl++;
         end
         if (m_cnt == 11'd0) begin
            if (prd_strt) prd0++;
         end else begin
            if (prd_strt) prdx++;
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b1;
      spd  = '0;
      spd4 = {11'h3FF, 11'h100, 11'h000, 11'h400};
      repeat (3) @(negedge clk);

      chk("rst_pwm1", 32'(pwm1), 32'd0);
      chk("rst_pwm2", 32'(pwm2), 32'd0);
      chk("rst_prd", 32'(prd_strt), 32'd0);
      chk("rst_q_pwm1", 32'(q_pwm1), 32'd0);
      chk("rst_q_pwm2", 32'(q_pwm2), 32'd0);
      rst = 1'b0;

      // 50% on both channels, two steady periods
      wait_cnt(11'd2047);
      wait_cnt(11'd2047);
      measure(4096);
      chk("t1_ch0_pwm1", 32'(p1[0]), 32'd2032);
      chk("t1_ch0_pwm2", 32'(p2[0]), 32'd2032);
      chk("t1_ch0_gap", 32'(bl[0]), 32'd32);
      chk("t1_ch1_pwm1", 32'(p1[1]), 32'd2032);
      chk("t1_ch1_pwm2", 32'(p2[1]), 32'd2032);
      chk("t1_ch1_gap", 32'(bl[1]), 32'd32);
      chk("t1_prd_at0", 32'(prd0), 32'd2);
      chk("t1_prd_else", 32'(prdx), 32'd0);
      chk("t6_q0_pwm1", 32'(q1[0]), 32'd0);
      chk("t6_q1_pwm1", 32'(q1[1]), 32'd2048);
      chk("t6_q2_pwm1", 32'(q1[2]), 32'd2560);
      chk("t6_q3_pwm1", 32'(q1[3]), 32'd4094);
      chk("t6_q0_pwm2", 32'(q2[0]), 32'd4096);
      chk("t6_q2_pwm2", 32'(q2[2]), 32'd1536);
      chk("t6_q3_pwm2", 32'(q2[3]), 32'd2);
      chk("t6_q_gap", 32'(qbl), 32'd0);
      chk("t1_overlap", 32'(ovl), 32'd0);

      // Full-scale commands, loaded at the wrap right after this sample
      spd[0  +: 11] = 11'h3FF;
      spd[11 +: 11] = 11'h400;
      wait_cnt(11'd2047);
      measure(2048);
      chk("t2_ch0_pwm1", 32'(p1[0]), 32'd2039);
      chk("t2_ch0_pwm2", 32'(p2[0]), 32'd0);
      chk("t2_ch0_gap", 32'(bl[0]), 32'd9);
      chk("t2_ch1_pwm1", 32'(p1[1]), 32'd0);
      chk("t2_ch1_pwm2", 32'(p2[1]), 32'd2048);
      chk("t2_overlap", 32'(ovl), 32'd0);

      // Mid-period speed change must wait for the wrap
      spd[0  +: 11] = 11'h000;
      spd[11 +: 11] = 11'h000;
      wait_cnt(11'd500);
      spd[0 +: 11] = 11'h200;
      wait_cnt(11'd1200);
      chk("t3_hold_pwm1", 32'(pwm1[0]), 32'd0);
      chk("t3_hold_pwm2", 32'(pwm2[0]), 32'd1);
      wait_cnt(11'd2047);
      measure(2048);
      chk("t3_ch0_pwm1", 32'(p1[0]), 32'd1528);
      chk("t3_ch0_pwm2", 32'(p2[0]), 32'd504);
      chk("t3_ch0_gap", 32'(bl[0]), 32'd16);
      chk("t3_ch1_pwm1", 32'(p1[1]), 32'd1016);
      chk("t3_prd_at0", 32'(prd0), 32'd1);

      // Enable drop and re-arm
      wait_cnt(11'd300);
      chk("t4_pre_pwm1", 32'(pwm1), 32'd3);
      chk("t4_pre_pwm2", 32'(pwm2), 32'd0);
      en = 1'b0;
      @(negedge clk);
      chk("t4_off_pwm1", 32'(pwm1), 32'd0);
      chk("t4_off_pwm2", 32'(pwm2), 32'd0);
      chk("t4_off_q", 32'({q_pwm1, q_pwm2}), 32'd0);
      nz = 0;
      repeat (20) begin
         @(negedge clk);
         if (pwm1 != 2'b00 || pwm2 != 2'b00 || q_pwm1 != 4'b0 || q_pwm2 != 4'b0) nz++;
      end
      chk("t4_off_hold", 32'(nz), 32'd0);
      en = 1'b1;
      nz = 0;
      @(negedge clk);
      chk("t4_q_pwm1_now", 32'(q_pwm1), 32'hE);
      chk("t4_q_pwm2_now", 32'(q_pwm2), 32'h1);
      if (pwm1 != 2'b00 || pwm2 != 2'b00) nz++;
      repeat (7) begin
         @(negedge clk);
         if (pwm1 != 2'b00 || pwm2 != 2'b00) nz++;
      end
      chk("t4_deadtime", 32'(nz), 32'd0);
      @(negedge clk);
      chk("t4_resume_pwm1", 32'(pwm1), 32'd3);
      chk("t4_resume_pwm2", 32'(pwm2), 32'd0);

      // Reset mid-period: duty falls back to half scale until the first wrap
      spd[0 +: 11] = 11'h3FF;
      wait_cnt(11'd700);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_pwm1", 32'(pwm1), 32'd0);
      chk("t5_rst_pwm2", 32'(pwm2), 32'd0);
      chk("t5_rst_prd", 32'(prd_strt), 32'd0);
      rst = 1'b0;
      measure(2047);
      chk("t5_ch0_pwm1", 32'(p1[0]), 32'd1016);
      chk("t5_ch1_pwm1", 32'(p1[1]), 32'd1016);
      chk("t5_q0_pwm1", 32'(q1[0]), 32'd1024);
      chk("t5_q3_pwm1", 32'(q1[3]), 32'd1024);
      chk("t5_prd_none", 32'(prd0 + prdx), 32'd0);
      chk("t5_overlap", 32'(ovl), 32'd0);
      @(negedge clk);
      chk("t5_prd_wrap", 32'(prd_strt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
